// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// funct3 load/store encodings, FSM state encoding and the store strobe helper.
package mem_access_ctrl_pkg;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

  // funct3[1:0] carries the access size; lane is already size-aligned.
  function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] strb;
    case (funct3[1:0])
      2'b00:   strb = 4'b0001 << lane;
      2'b01:   strb = 4'b0011 << lane;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data shift and strobes, load
// byte/half extraction with sign or zero extension. Misalignment is not trapped.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  store_wstrb,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [1:0]  lane;
  logic [31:0] load_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfwords ignore addr[0]; words ignore both low address bits.
  always_comb begin
    case (funct3[1:0])
      2'b00:   lane = addr_lo;
      2'b01:   lane = {addr_lo[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  assign store_wstrb  = store_strb(funct3, lane);
  assign store_lanes  = store_data << {lane, 3'b000};
  assign load_shifted = load_word >> {lane, 3'b000};
  assign ld_byte      = load_shifted[7:0];
  assign ld_half      = load_shifted[15:0];

  always_comb begin
    case (funct3)
      Funct3B:  load_data = {{24{ld_byte[7]}}, ld_byte};
      Funct3Bu: load_data = {24'h0, ld_byte};
      Funct3H:  load_data = {{16{ld_half[15]}}, ld_half};
      Funct3Hu: load_data = {16'h0, ld_half};
      default:  load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage req/ack data-memory controller producing MEM_DONE for the hazard unit.
// Optional abort of a stuck transaction when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  output logic [31:0] MEM_rdata,
  output logic        MEM_DONE,
  output logic        MEM_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        access;
  logic [3:0]  lane_wstrb;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
`endif

  assign access = MEM_mem_read | MEM_mem_write;

  // Reset gates the bus and releases the pipeline even if access is held.
  assign mem_req  = rstn & access & ((state_q == StIdle) | (state_q == StWait));
  assign MEM_DONE = ~rstn | ((state_q == StIdle) & ~access) | (state_q == StDone);

  assign mem_we    = MEM_mem_write;
  assign mem_addr  = {MEM_addr[31:2], 2'b00};
  assign mem_wstrb = MEM_mem_write ? lane_wstrb : 4'b0000;

  mem_lane_align u_lane_align (
    .funct3      (MEM_funct3),
    .addr_lo     (MEM_addr[1:0]),
    .store_data  (MEM_wdata),
    .load_word   (rdata_q),
    .store_wstrb (lane_wstrb),
    .store_lanes (mem_wdata),
    .load_data   (MEM_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (access) begin
            if (mem_ack) begin
              state_q <= StDone;
              rdata_q <= mem_rdata;
            end else begin
              state_q <= StWait;
`ifdef MEM_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end
        end
        StWait: begin
          if (mem_ack) begin
            state_q <= StDone;
            rdata_q <= mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
          // Abort: release the pipeline with a zero result; a pending store is lost.
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= StDone;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign MEM_err = err_q;
`else
  assign MEM_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the memory side is driven by hand.
// The timeout scenario is built only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        MEM_mem_read, MEM_mem_write;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_addr, MEM_wdata, MEM_rdata;
  logic        MEM_DONE, MEM_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .MEM_mem_read  (MEM_mem_read),
    .MEM_mem_write (MEM_mem_write),
    .MEM_funct3    (MEM_funct3),
    .MEM_addr      (MEM_addr),
    .MEM_wdata     (MEM_wdata),
    .MEM_rdata     (MEM_rdata),
    .MEM_DONE      (MEM_DONE),
    .MEM_err       (MEM_err),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Runs one transaction from IDLE: 1 + waits stall cycles, ending at the DONE sample point.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int waits, input string tag);
    MEM_mem_read  = rd;
    MEM_mem_write = wr;
    MEM_funct3    = f3;
    MEM_addr      = addr;
    MEM_wdata     = wdata;
    mem_rdata     = rdata;
    for (int i = 0; i <= waits; i++) begin
      mem_ack = (i == waits);
      settle();
      check({tag, " stall done"}, {31'h0, MEM_DONE}, 32'd0);
      check({tag, " stall req"}, {31'h0, mem_req}, 32'd1);
      cyc();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    settle();
    check({tag, " done"}, {31'h0, MEM_DONE}, 32'd1);
    check({tag, " done req"}, {31'h0, mem_req}, 32'd0);
    check({tag, " done err"}, {31'h0, MEM_err}, 32'd0);
  endtask

  // Leaves DONE, drops the access and stops one cycle into IDLE.
  task automatic retire(input string tag);
    cyc();
    MEM_mem_read  = 1'b0;
    MEM_mem_write = 1'b0;
    settle();
    check({tag, " idle done"}, {31'h0, MEM_DONE}, 32'd1);
    cyc();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] lanes;
  } st_vec_t;

  st_vec_t st_vecs[5] = '{
    '{Funct3H, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 4'b1100, 32'hABCD_0000},
    '{Funct3B, 1'b0, 32'h0000_0101, 32'h0000_00A5, 4'b0010, 32'h0000_A500},
    '{Funct3B, 1'b0, 32'h0000_0103, 32'h1234_5677, 4'b1000, 32'h7700_0000},
    '{Funct3W, 1'b0, 32'h0000_010A, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE},
    '{Funct3W, 1'b1, 32'h0000_0204, 32'h0102_0304, 4'b1111, 32'h0102_0304}
  };

  initial begin
    rstn          = 1'b0;
    MEM_mem_read  = 1'b1;
    MEM_mem_write = 1'b0;
    MEM_funct3    = Funct3W;
    MEM_addr      = 32'h0;
    MEM_wdata     = 32'h0;
    mem_ack       = 1'b0;
    mem_rdata     = 32'h0;

    // Reset state, with a load presented to prove the bus stays quiet.
    #2;
    check("rst req", {31'h0, mem_req}, 32'd0);
    check("rst done", {31'h0, MEM_DONE}, 32'd1);
    check("rst err", {31'h0, MEM_err}, 32'd0);
    check("rst rdata", MEM_rdata, 32'h0);
    MEM_mem_read = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
    settle();
    check("idle done", {31'h0, MEM_DONE}, 32'd1);
    check("idle req", {31'h0, mem_req}, 32'd0);
    cyc();

    // lw, zero-wait memory: exactly one stall cycle.
    issue(1'b1, 1'b0, Funct3W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, "lw0");
    check("lw0 rdata", MEM_rdata, 32'hDEAD_BEEF);
    check("lw0 addr", mem_addr, 32'h100);
    retire("lw0");

    // Loads with lane extraction and extension.
    issue(1'b1, 1'b0, Funct3B, 32'h103, 32'h0, 32'h8011_2233, 3, "lb3");
    check("lb3 rdata", MEM_rdata, 32'hFFFF_FF80);
    retire("lb3");
    issue(1'b1, 1'b0, Funct3Bu, 32'h103, 32'h0, 32'h8011_2233, 0, "lbu");
    check("lbu rdata", MEM_rdata, 32'h0000_0080);
    retire("lbu");
    issue(1'b1, 1'b0, Funct3H, 32'h102, 32'h0, 32'h8011_2233, 1, "lh");
    check("lh rdata", MEM_rdata, 32'hFFFF_8011);
    retire("lh");
    issue(1'b1, 1'b0, Funct3Hu, 32'h103, 32'h0, 32'h8011_2233, 0, "lhu_a0");
    check("lhu_a0 rdata", MEM_rdata, 32'h0000_8011);
    retire("lhu_a0");
    issue(1'b1, 1'b0, Funct3Hu, 32'h001, 32'h0, 32'h8011_2233, 0, "lhu_lo");
    check("lhu_lo rdata", MEM_rdata, 32'h0000_2233);
    retire("lhu_lo");

    // Stores: lanes and strobes are checked in the request cycle.
    foreach (st_vecs[i]) begin
      MEM_mem_read  = st_vecs[i].rd;
      MEM_mem_write = 1'b1;
      MEM_funct3    = st_vecs[i].f3;
      MEM_addr      = st_vecs[i].addr;
      MEM_wdata     = st_vecs[i].wdata;
      mem_ack       = 1'b1;
      settle();
      check($sformatf("st%0d strb", i), {28'h0, mem_wstrb}, {28'h0, st_vecs[i].strb});
      check($sformatf("st%0d wdata", i), mem_wdata, st_vecs[i].lanes);
      check($sformatf("st%0d addr", i), mem_addr, {st_vecs[i].addr[31:2], 2'b00});
      check($sformatf("st%0d we", i), {31'h0, mem_we}, 32'd1);
      check($sformatf("st%0d req", i), {31'h0, mem_req}, 32'd1);
      cyc();
      mem_ack = 1'b0;
      settle();
      check($sformatf("st%0d done", i), {31'h0, MEM_DONE}, 32'd1);
      retire($sformatf("st%0d", i));
    end

    // A load drives no strobes.
    MEM_mem_read = 1'b1;
    MEM_funct3   = Funct3B;
    MEM_addr     = 32'h101;
    settle();
    check("ld strb", {28'h0, mem_wstrb}, 32'h0);
    check("ld we", {31'h0, mem_we}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_7F00;
    cyc();
    mem_ack = 1'b0;
    settle();
    check("lb pos rdata", MEM_rdata, 32'h0000_007F);
    retire("lb_pos");

    // Back-to-back lw: ack lingering through DONE must not satisfy the second load.
    MEM_mem_read = 1'b1;
    MEM_funct3   = Funct3W;
    MEM_addr     = 32'h300;
    mem_ack      = 1'b1;
    mem_rdata    = 32'h1111_1111;
    settle();
    check("b2b first req", {31'h0, mem_req}, 32'd1);
    cyc();
    mem_rdata = 32'h2222_2222;
    settle();
    check("b2b done req", {31'h0, mem_req}, 32'd0);
    check("b2b first rdata", MEM_rdata, 32'h1111_1111);
    cyc();
    MEM_addr = 32'h304;
    mem_ack  = 1'b0;
    settle();
    check("b2b second req", {31'h0, mem_req}, 32'd1);
    check("b2b second stall", {31'h0, MEM_DONE}, 32'd0);
    cyc();
    settle();
    check("b2b no reuse", {31'h0, MEM_DONE}, 32'd0);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 32'h3333_3333;
    cyc();
    mem_ack = 1'b0;
    settle();
    check("b2b second rdata", MEM_rdata, 32'h3333_3333);
    check("b2b second done", {31'h0, MEM_DONE}, 32'd1);
    retire("b2b");

    // Reset during WAIT, then a stale ack while idle.
    MEM_mem_read = 1'b1;
    MEM_funct3   = Funct3W;
    MEM_addr     = 32'h200;
    cyc();
    settle();
    check("rstw wait", {31'h0, MEM_DONE}, 32'd0);
    cyc();
    rstn = 1'b0;
    #1;
    check("rstw req", {31'h0, mem_req}, 32'd0);
    check("rstw done", {31'h0, MEM_DONE}, 32'd1);
    MEM_mem_read = 1'b0;
    cyc();
    rstn      = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    settle();
    check("stale req", {31'h0, mem_req}, 32'd0);
    cyc();
    mem_ack      = 1'b0;
    MEM_mem_read = 1'b1;
    settle();
    check("stale no done", {31'h0, MEM_DONE}, 32'd0);
    check("stale rdata", MEM_rdata, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    cyc();
    mem_ack = 1'b0;
    settle();
    check("post rst rdata", MEM_rdata, 32'h0BAD_F00D);
    retire("post_rst");

`ifdef MEM_TIMEOUT_EN
    // No ack: 1 + 4 stall cycles, then DONE with a zero result and a single err pulse.
    MEM_mem_read = 1'b1;
    MEM_funct3   = Funct3W;
    MEM_addr     = 32'h400;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("to stall%0d", i), {31'h0, MEM_DONE}, 32'd0);
      check($sformatf("to err%0d", i), {31'h0, MEM_err}, 32'd0);
      cyc();
    end
    settle();
    check("to done", {31'h0, MEM_DONE}, 32'd1);
    check("to err pulse", {31'h0, MEM_err}, 32'd1);
    check("to rdata", MEM_rdata, 32'h0);
    cyc();
    MEM_mem_read = 1'b0;
    settle();
    check("to err clear", {31'h0, MEM_err}, 32'd0);
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
